pong_game_ctrl: RTL



---
 rtl/pong_game_ctrl_pkg.sv | 19 +
 rtl/pong_bcd_score.sv | 52 +++++
 rtl/pong_game_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// Shared Pong definitions: game-state encoding (also read by the text overlay),
// countdown timer full scale and a BCD digit helper.
package pong_game_ctrl_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } game_state_t;

    localparam logic [6:0] TIMER_FULL = 7'd127;

    // Out-of-range codes wrap to 0 so a digit can never leave 0..9.
    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : (d + 4'd1);
    endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// Two-digit BCD score counter: 99 wraps to 00, clear wins over increment.
module pong_bcd_score
    import pong_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] dig1,
    output logic [3:0] dig0
);

    logic [3:0] dig1_r;
    logic [3:0] dig0_r;
    logic [3:0] dig1_next_s;
    logic [3:0] dig0_next_s;

    // Next-digit computation with carry from units into tens.
    always_comb begin
        dig1_next_s = dig1_r;
        dig0_next_s = dig0_r;
        if (clr) begin
            dig1_next_s = 4'd0;
            dig0_next_s = 4'd0;
        end else if (inc) begin
            dig0_next_s = bcd_next(dig0_r);
            if (dig0_r >= 4'd9) begin
                dig1_next_s = bcd_next(dig1_r);
            end else begin
                dig1_next_s = dig1_r;
            end
        end else begin
            dig1_next_s = dig1_r;
            dig0_next_s = dig0_r;
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig1_r <= 4'd0;
            dig0_r <= 4'd0;
        end else begin
            dig1_r <= dig1_next_s;
            dig0_r <= dig0_next_s;
        end
    end

    assign dig1 = dig1_r;
    assign dig0 = dig0_r;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: new game, play, ball relaunch and game over,
// plus score and remaining-ball bookkeeping for the text overlay.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int NUM_BALLS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    input  logic       timer_up,
    output logic       timer_start,
    output logic       graph_still,
    output logic [1:0] game_state,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic [1:0] balls_left
);

    localparam logic [1:0] BALLS_FULL = 2'(NUM_BALLS);

    game_state_t state_r;
    game_state_t state_next_s;
    logic [1:0]  balls_r;
    logic [1:0]  balls_next_s;
    logic        graph_still_r;
    logic        timer_start_s;
    logic        score_clr_s;
    logic        score_inc_s;
    logic        btn_any_s;

    assign btn_any_s = (btn != 2'b00);

    // Next-state, ball bookkeeping and timer strobe; hit/miss only matter in PLAY.
    always_comb begin
        state_next_s  = state_r;
        balls_next_s  = balls_r;
        timer_start_s = 1'b0;
        score_clr_s   = 1'b0;
        score_inc_s   = 1'b0;
        case (state_r)
            NEWGAME: begin
                balls_next_s = BALLS_FULL;
                if (btn_any_s) begin
                    state_next_s = PLAY;
                    score_clr_s  = 1'b1;
                    balls_next_s = BALLS_FULL - 2'd1;
                end else begin
                    state_next_s = NEWGAME;
                end
            end
            PLAY: begin
                score_inc_s = hit;
                if (miss) begin
                    timer_start_s = 1'b1;
                    if (balls_r == 2'd0) begin
                        state_next_s = OVER;
                    end else begin
                        state_next_s = NEWBALL;
                        balls_next_s = balls_r - 2'd1;
                    end
                end else begin
                    state_next_s = PLAY;
                end
            end
            NEWBALL: begin
                if (timer_up && btn_any_s) begin
                    state_next_s = PLAY;
                end else begin
                    state_next_s = NEWBALL;
                end
            end
            OVER: begin
                if (timer_up) begin
                    state_next_s = NEWGAME;
                end else begin
                    state_next_s = OVER;
                end
            end
            default: begin
                state_next_s = NEWGAME;
                balls_next_s = BALLS_FULL;
            end
        endcase
    end

    // State, ball count and the registered freeze flag (low only while in PLAY).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= NEWGAME;
            balls_r       <= BALLS_FULL;
            graph_still_r <= 1'b1;
        end else begin
            state_r       <= state_next_s;
            balls_r       <= balls_next_s;
            graph_still_r <= (state_next_s != PLAY);
        end
    end

    pong_bcd_score u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr_s),
        .inc   (score_inc_s),
        .dig1  (dig1),
        .dig0  (dig0)
    );

    assign timer_start = timer_start_s;
    assign graph_still = graph_still_r;
    assign game_state  = state_r;
    assign balls_left  = balls_r;

endmodule
